// File: rtl/mmc1_serial_regs_if.sv
// rtl/mmc1_serial_regs_if.sv - CPU write bus into the MMC1 serial register front end
interface mmc1_serial_regs_if;
  logic       wr;
  logic [1:0] addr;
  logic       d0;
  logic       d7;

  modport master (output wr, output addr, output d0, output d7);
  modport slave  (input wr, input addr, input d0, input d7);
endinterface

// File: rtl/mmc1_serial_regs.sv
// rtl/mmc1_serial_regs.sv - MMC1 serial load, register file and bank line decode
module mmc1_serial_regs (
  input  logic                    ck,
  input  logic                    nres,
  mmc1_serial_regs_if.slave       bus,
  input  logic                    cpu_a14,
  input  logic [2:0]              ppu_a,
  output logic [3:0]              prg_a,
  output logic [4:0]              chr_a,
  output logic                    ciram_a10,
  output logic                    wram_ce_n,
  output logic [4:0]              ctrl,
  output logic [4:0]              chr0,
  output logic [4:0]              chr1,
  output logic [4:0]              prg
);

  logic [3:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_q;
  logic [4:0] ctrl_q, ctrl_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;
  logic       accept;

  // Only the first cycle of a write burst counts, so RMW double writes collapse to one.
  assign accept = bus.wr & ~wr_q;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    ctrl_d = ctrl_q;
    chr0_d = chr0_q;
    chr1_d = chr1_q;
    prg_d  = prg_q;
    if (accept) begin
      if (bus.d7) begin
        sr_d        = 4'h0;
        cnt_d       = 3'd0;
        ctrl_d[3:2] = 2'b11;
      end else if (cnt_q == 3'd4) begin
        case (bus.addr)
          2'd0:    ctrl_d = {bus.d0, sr_q};
          2'd1:    chr0_d = {bus.d0, sr_q};
          2'd2:    chr1_d = {bus.d0, sr_q};
          default: prg_d  = {bus.d0, sr_q};
        endcase
        sr_d  = 4'h0;
        cnt_d = 3'd0;
      end else begin
        sr_d  = {bus.d0, sr_q[3:1]};
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge ck or negedge nres) begin
    if (!nres) begin
      sr_q   <= 4'h0;
      cnt_q  <= 3'd0;
      wr_q   <= 1'b0;
      ctrl_q <= 5'b01100;
      chr0_q <= 5'h00;
      chr1_q <= 5'h00;
      prg_q  <= 5'h00;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      wr_q   <= bus.wr;
      ctrl_q <= ctrl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q  <= prg_d;
    end
  end

  always_comb begin
    case (ctrl_q[1:0])
      2'd0:    ciram_a10 = 1'b0;
      2'd1:    ciram_a10 = 1'b1;
      2'd2:    ciram_a10 = ppu_a[0];
      default: ciram_a10 = ppu_a[1];
    endcase
  end

  always_comb begin
    case (ctrl_q[3:2])
      2'd2:    prg_a = cpu_a14 ? prg_q[3:0] : 4'h0;
      2'd3:    prg_a = cpu_a14 ? 4'hF : prg_q[3:0];
      default: prg_a = {prg_q[3:1], cpu_a14};
    endcase
  end

  assign chr_a     = ctrl_q[4] ? (ppu_a[2] ? chr1_q : chr0_q) : {chr0_q[4:1], ppu_a[2]};
  assign wram_ce_n = prg_q[4];
  assign ctrl      = ctrl_q;
  assign chr0      = chr0_q;
  assign chr1      = chr1_q;
  assign prg       = prg_q;

endmodule
